// File: rtl/calendar_set_ctrl.sv
// calendar_set_ctrl: one-second tick generator and front-panel time-set sequencer for the calendar counter.
// Latency: a button level seen at clock n acts at clock n+1; tick, load, field and blink are registered.
// Backpressure: none; the counter core must accept tick/load whenever they are asserted.
//
// Ports:
//   clk, rst                 clock and async active-high reset
//   btn_mode, btn_inc        debounced button levels (rising edge = press)
//   cur_*                    live counter fields, snapshotted when editing starts
//   tick                     one-cycle advance enable, RUN only
//   load, ld_*               one-cycle parallel-load strobe and the shadow values it carries
//   field, blink             field under edit (0 = RUN) and display blink phase
module calendar_set_ctrl #(
   parameter int TICK_DIV = 50000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_mode,
   input  logic        btn_inc,
   input  logic [5:0]  cur_sec,
   input  logic [5:0]  cur_min,
   input  logic [4:0]  cur_hour,
   input  logic [4:0]  cur_day,
   input  logic [3:0]  cur_month,
   input  logic [13:0] cur_year,
   output logic        tick,
   output logic        load,
   output logic [5:0]  ld_sec,
   output logic [5:0]  ld_min,
   output logic [4:0]  ld_hour,
   output logic [4:0]  ld_day,
   output logic [3:0]  ld_month,
   output logic [13:0] ld_year,
   output logic [2:0]  field,
   output logic        blink
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] PRE_MAX = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] BLK_MAX = CW'(TICK_DIV / 2 - 1);

   // Encoding of the SET states equals the field number shown on the display.
   typedef enum logic [2:0] {
      ST_RUN    = 3'd0,
      ST_HOUR   = 3'd1,
      ST_MIN    = 3'd2,
      ST_SEC    = 3'd3,
      ST_DAY    = 3'd4,
      ST_MONTH  = 3'd5,
      ST_YEAR   = 3'd6,
      ST_COMMIT = 3'd7
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_mode_lvl, r_mode_prev, r_inc_lvl, r_inc_prev;
   logic [CW-1:0] r_presc, r_bcnt;
   logic          r_tick, r_load, r_blink;
   logic [2:0]    r_field;
   logic [5:0]    r_sec, r_min;
   logic [4:0]    r_hour, r_day;
   logic [3:0]    r_month;
   logic [13:0]   r_year;

   logic          w_mode_edge, w_inc_edge, w_inc_apply, w_nxt_set;
   logic [3:0]    w_month_inc;
   logic [13:0]   w_year_inc;
   logic [4:0]    w_dim_cur, w_day_mclamp, w_day_yclamp;

   function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [13:0] y);
      logic [4:0] d;
      case (m)
         4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
         4'd2:                    d = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
         default:                 d = 5'd31;
      endcase
      return d;
   endfunction

   function automatic logic [4:0] clamp_day(input logic [4:0] d, input logic [4:0] lim);
      return (d > lim) ? lim : d;
   endfunction

   // Edge detection works on the registered level so a press acts one clock after it is seen.
   assign w_mode_edge = r_mode_lvl & ~r_mode_prev;
   assign w_inc_edge  = r_inc_lvl  & ~r_inc_prev;

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == ST_COMMIT)
         w_state_nxt = ST_RUN;
      else if (w_mode_edge)
         w_state_nxt = state_t'(r_state + 3'd1);
   end

   assign w_nxt_set   = (w_state_nxt != ST_RUN) && (w_state_nxt != ST_COMMIT);
   // Mode wins over a simultaneous inc; inc is meaningless outside the SET states.
   assign w_inc_apply = w_inc_edge && !w_mode_edge && (r_state != ST_RUN) && (r_state != ST_COMMIT);

   assign w_month_inc  = (r_month == 4'd12) ? 4'd1 : r_month + 4'd1;
   assign w_year_inc   = (r_year == 14'd9999) ? 14'd0 : r_year + 14'd1;
   assign w_dim_cur    = days_in_month(r_month, r_year);
   assign w_day_mclamp = clamp_day(r_day, days_in_month(w_month_inc, r_year));
   assign w_day_yclamp = clamp_day(r_day, days_in_month(r_month, w_year_inc));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_RUN;
         r_mode_lvl  <= 1'b0;
         r_mode_prev <= 1'b0;
         r_inc_lvl   <= 1'b0;
         r_inc_prev  <= 1'b0;
         r_presc     <= '0;
         r_bcnt      <= '0;
         r_tick      <= 1'b0;
         r_load      <= 1'b0;
         r_field     <= 3'd0;
         r_blink     <= 1'b0;
         r_sec       <= 6'd0;
         r_min       <= 6'd0;
         r_hour      <= 5'd0;
         r_day       <= 5'd1;
         r_month     <= 4'd1;
         r_year      <= 14'd2024;
      end else begin
         r_mode_lvl  <= btn_mode;
         r_mode_prev <= r_mode_lvl;
         r_inc_lvl   <= btn_inc;
         r_inc_prev  <= r_inc_lvl;
         r_state     <= w_state_nxt;
         r_load      <= (w_state_nxt == ST_COMMIT);
         r_field     <= (w_state_nxt == ST_COMMIT) ? 3'd0 : 3'(w_state_nxt);

         // Prescaler only runs while staying in RUN, so a tick due on the
         // cycle RUN is left is dropped rather than landing in SET_HOUR.
         if (r_state == ST_RUN && w_state_nxt == ST_RUN)
            r_presc <= (r_presc == PRE_MAX) ? '0 : r_presc + 1'b1;
         else
            r_presc <= '0;
         r_tick <= (r_state == ST_RUN) && (w_state_nxt == ST_RUN) && (r_presc == PRE_MAX);

         if (!w_nxt_set) begin
            r_bcnt  <= '0;
            r_blink <= 1'b0;
         end else if (w_state_nxt != r_state) begin
            r_bcnt  <= '0;
            r_blink <= 1'b1;
         end else if (r_bcnt == BLK_MAX) begin
            r_bcnt  <= '0;
            r_blink <= ~r_blink;
         end else begin
            r_bcnt  <= r_bcnt + 1'b1;
         end

         if (r_state == ST_RUN && w_state_nxt == ST_HOUR) begin
            r_sec   <= cur_sec;
            r_min   <= cur_min;
            r_hour  <= cur_hour;
            r_day   <= cur_day;
            r_month <= cur_month;
            r_year  <= cur_year;
         end else if (w_inc_apply) begin
            case (r_state)
               ST_HOUR:  r_hour <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
               ST_MIN:   r_min  <= (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
               ST_SEC:   r_sec  <= (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
               ST_DAY:   r_day  <= (r_day >= w_dim_cur) ? 5'd1 : r_day + 5'd1;
               ST_MONTH: begin
                  r_month <= w_month_inc;
                  r_day   <= w_day_mclamp;
               end
               ST_YEAR: begin
                  r_year <= w_year_inc;
                  r_day  <= w_day_yclamp;
               end
               default: ;
            endcase
         end
      end
   end

   assign tick     = r_tick;
   assign load     = r_load;
   assign field    = r_field;
   assign blink    = r_blink;
   assign ld_sec   = r_sec;
   assign ld_min   = r_min;
   assign ld_hour  = r_hour;
   assign ld_day   = r_day;
   assign ld_month = r_month;
   assign ld_year  = r_year;

endmodule

// File: doc/calendar_set_ctrl.md
# calendar_set_ctrl

Sequencing controller for the calendar/time counter datapath. It generates the one-second advance enable (`tick`) while the clock runs. It also runs the user time-set sequence: it snapshots the counter's current fields, lets the user edit them with two buttons, and commits the edited values through a one-cycle parallel `load` strobe. It sits between the debounced/synchronised front-panel buttons and the counter core, and drives field-select and blink hints to the 7-segment display path.

## Interface
Parameters:
- `TICK_DIV`, default 50000000: clock cycles per second tick; must be an even number ≥ 4.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `btn_mode`  in  1  mode button level, already synchronised and debounced.
- `btn_inc`  in  1  increment button level, already synchronised and debounced.
- `cur_sec`, `cur_min`  in  6 each  live counter values, 0–59.
- `cur_hour`  in  5  live hour, 0–23.
- `cur_day`  in  5  live day, 1–31.
- `cur_month`  in  4  live month, 1–12.
- `cur_year`  in  14  live year, 0–9999.
- `tick`  out  1  one-cycle counter advance enable.
- `load`  out  1  one-cycle parallel-load strobe to the counter.
- `ld_sec`, `ld_min`, `ld_hour`, `ld_day`, `ld_month`, `ld_year`  out  same widths as `cur_*`  load values. These are continuous views of the shadow registers and are valid whenever `load`=1.
- `field`  out  3  field being edited: 0 RUN, 1 hour, 2 min, 3 sec, 4 day, 5 month, 6 year.
- `blink`  out  1  display blink phase for the edited field.

## Operation
- Button press = rising edge. The block registers each button's previous level and detects an edge when the level is 1 and the previous level is 0.
- State machine: RUN → SET_HOUR → SET_MIN → SET_SEC → SET_DAY → SET_MONTH → SET_YEAR → COMMIT → RUN.
  - A mode edge advances one state.
  - COMMIT lasts exactly one cycle and advances unconditionally.
- Snapshot: on the RUN→SET_HOUR transition, all six `cur_*` values are copied into the shadow registers.
- An inc edge in a SET state increments only that state's shadow field, with wrap:
  - hour: 23→0
  - min and sec: 59→0
  - day: DIM→1
  - month: 12→1
  - year: 9999→0
- DIM (days in month):
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - For month 2: 29 when year mod 4 = 0, otherwise 28.
- Day clamp: whenever shadow month or year changes, shadow day is set to min(day, DIM of the new month/year) in the same cycle.
- Simultaneous mode and inc edges: mode wins and the inc edge is discarded.
- Inc edges in RUN and COMMIT are ignored. Mode edges in COMMIT are ignored.
- `load` = 1 only in COMMIT (Moore output).
- `field` = encoding of the current state; COMMIT reports 0.
- Prescaler:
  - In RUN it counts 0..TICK_DIV-1 and wraps.
  - In all other states it is held at 0.
- `tick` is a registered output. It is 1 for the cycle after the prescaler equals TICK_DIV-1, and only while the state is RUN. `tick` is never asserted in SET states or COMMIT.
- Blink:
  - In SET states, a separate counter toggles `blink` every TICK_DIV/2 cycles.
  - On entry to each SET state, the counter is cleared and `blink` is set to 1.
  - In RUN, `blink` = 0.

## Timing
- Reset values while `rst`=1, applied asynchronously:
  - state RUN, prescaler 0, blink counter 0, button history 0.
  - `tick`=0, `load`=0, `field`=0, `blink`=0.
  - shadow registers, and therefore the `ld_*` outputs: sec 0, min 0, hour 0, day 1, month 1, year 2024.
- Reset mid-edit discards the shadow edits; no `load` is issued.
- An edge whose level is seen at clock n changes state and shadow values at edge n+1. A button held high produces only one edge.
- Commit timing, for a mode edge seen in SET_YEAR at cycle n:
  - state is COMMIT and `load`=1 during cycle n+1;
  - state is RUN at cycle n+2, with the prescaler at 0;
  - the first `tick` is asserted at cycle n+2+TICK_DIV.
- In continuous RUN, `tick` has period exactly TICK_DIV cycles.
- The counter core samples the `ld_*` values only when `load`=1. `tick` and `load` are never both 1 in the same cycle.

## Test plan
- Reset with TICK_DIV=4, then hold the buttons low → `tick` pulses every 4 cycles; `field`=0; `ld_year`=2024, `ld_day`=1.
- Start with `cur_*` = 23:59:58, 31/12/2023. Press mode once, then inc once → `field`=1, `ld_hour`=0 (wrapped), all other shadows match `cur_*`, no `tick` while editing.
- Snapshot day 31 and month 1, advance to SET_MONTH, press inc → `ld_month`=2, `ld_day`=29 when year=2024; repeat with year=2023 → `ld_day`=28.
- Advance to SET_YEAR with shadow 29/02/2024 and press inc → year 2025 and day clamped to 28. Separately, year 9999 plus inc → 0.
- From SET_YEAR, press mode → `load`=1 for exactly one cycle carrying all shadow values, then RUN, with the first `tick` 4 cycles later.
- Assert `btn_mode` and `btn_inc` edges in the same cycle → only the state advances. Then pulse `rst` mid-edit → immediately RUN, `load` never asserted, shadows return to reset values.
